// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the RV32I multi-cycle sequencer
// Contents: opcode constants, immediate-format select, pc_sel/wb_sel
// encodings, sequencer state enum and instruction class enum.
// Optional feature macro: MC_CTRL_TRAP_EN (adds the TRAP state).
package mc_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Immediate-format select, shared with the immediate generator
    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef MC_CTRL_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_R,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR
    } class_e;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode to {class, immsel, legal} mapping
// Ports:
//   opcode_i  in  7  instruction opcode field inst[6:0]
//   cls_o     out    instruction class (CL_NONE when illegal)
//   immsel_o  out 3  immediate format for this class
//   legal_o   out 1  opcode belongs to a supported class
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode_i,
    output class_e     cls_o,
    output logic [2:0] immsel_o,
    output logic       legal_o
);

    always_comb begin
        cls_o    = CL_NONE;
        immsel_o = IMM_R;
        legal_o  = 1'b1;
        case (opcode_i)
            OP_R:      begin cls_o = CL_R;      immsel_o = IMM_R; end
            OP_IALU:   begin cls_o = CL_IALU;   immsel_o = IMM_I; end
            OP_LOAD:   begin cls_o = CL_LOAD;   immsel_o = IMM_I; end
            OP_STORE:  begin cls_o = CL_STORE;  immsel_o = IMM_S; end
            OP_BRANCH: begin cls_o = CL_BRANCH; immsel_o = IMM_B; end
            OP_JAL:    begin cls_o = CL_JAL;    immsel_o = IMM_J; end
            OP_JALR:   begin cls_o = CL_JALR;   immsel_o = IMM_I; end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Ports:
//   clk, rst (sync, active-high)
//   inst       in  N  instruction register contents
//   mem_ready  in  1  shared memory port accepted/completed request
//   br_taken   in  1  branch comparator result
//   immsel, ir_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel,
//   alu_src_b, alu_fn, rf_we, wb_sel, illegal  out  datapath controls
// Optional feature macro: MC_CTRL_TRAP_EN (illegal opcode traps until reset;
// otherwise an illegal opcode retires as a NOP).
module mc_control
    import mc_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] inst,
    input  logic         mem_ready,
    input  logic         br_taken,
    output logic [2:0]   immsel,
    output logic         ir_we,
    output logic         pc_we,
    output logic [1:0]   pc_sel,
    output logic         mem_req,
    output logic         mem_we,
    output logic         mem_addr_sel,
    output logic         alu_src_b,
    output logic [3:0]   alu_fn,
    output logic         rf_we,
    output logic [1:0]   wb_sel,
    output logic         illegal
);

    state_e     state_q, state_d;
    class_e     cls_q;
    logic [2:0] immsel_q;

    class_e     dec_cls;
    logic [2:0] dec_immsel;
    logic       dec_legal;

    mc_decode u_decode (
        .opcode_i (inst[6:0]),
        .cls_o    (dec_cls),
        .immsel_o (dec_immsel),
        .legal_o  (dec_legal)
    );

    // State register; class and immsel are captured at the end of DECODE
    // and held until the next DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            cls_q    <= CL_NONE;
            immsel_q <= IMM_R;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q    <= dec_cls;
                immsel_q <= dec_immsel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef MC_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_R, CL_IALU:     state_d = ST_WB;
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) state_d = (cls_q == CL_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB: state_d = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // ALU controls derived from the latched class; address computation for
    // load/store/JALR always needs a plain add.
    logic       alu_src_b_c;
    logic [3:0] alu_fn_c;

    always_comb begin
        alu_src_b_c = (cls_q != CL_R) && (cls_q != CL_BRANCH);
        if (cls_q == CL_LOAD || cls_q == CL_STORE || cls_q == CL_JALR) begin
            alu_fn_c = 4'b0000;
        end else begin
            alu_fn_c = {inst[30], inst[14:12]};
        end
    end

    // Outputs are all forced low while rst is high, whatever the state.
    always_comb begin
        immsel       = IMM_R;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_b    = 1'b0;
        alu_fn       = 4'b0000;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        illegal      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_DECODE: begin
                    // immsel comes straight from decode so it is valid in DECODE
                    immsel = dec_immsel;
`ifndef MC_CTRL_TRAP_EN
                    if (!dec_legal) pc_we = 1'b1;
`endif
                end
                ST_EXEC: begin
                    immsel    = immsel_q;
                    alu_src_b = alu_src_b_c;
                    alu_fn    = alu_fn_c;
                    case (cls_q)
                        CL_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                        end
                        CL_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_IMM;
                        end
                        CL_JALR: begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    immsel       = immsel_q;
                    alu_src_b    = alu_src_b_c;
                    alu_fn       = alu_fn_c;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == CL_STORE);
                    if (mem_ready && cls_q == CL_STORE) pc_we = 1'b1;
                end
                ST_WB: begin
                    immsel    = immsel_q;
                    alu_src_b = alu_src_b_c;
                    alu_fn    = alu_fn_c;
                    rf_we     = 1'b1;
                    wb_sel    = (cls_q == CL_LOAD) ? WB_MEM : WB_ALU;
                    pc_we     = 1'b1;
                end
`ifdef MC_CTRL_TRAP_EN
                ST_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencer for the RV32I core datapath. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives the immediate-format select into the immediate generator, and the PC, instruction-register, ALU, memory and register-file enables. Handshakes with a single shared instruction/data memory port.

## Interface
- N, 32, instruction/data width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst  in  N  instruction register contents (valid from DECODE onward)
- mem_ready  in  1  memory accepted/completed current request
- br_taken  in  1  branch comparator result for current instruction
- immsel  out  3  format to immediate generator: R=0, I=1, S=2, B=3, J=4
- ir_we  out  1  load instruction register from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared
- mem_req  out  1  memory request
- mem_we  out  1  store (valid only while mem_req)
- mem_addr_sel  out  1  0=PC, 1=ALU result
- alu_src_b  out  1  0=rs2, 1=imm
- alu_fn  out  4  {funct7[5], funct3}; forced 4'b0000 (add) for load/store/JALR
- rf_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
- illegal  out  1  sticky illegal-instruction flag (see Configuration)

## Operation
- Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111. All other opcodes, including LUI/AUIPC, are illegal.
- DECODE latches class and immsel. immsel is held constant from DECODE until the return to FETCH: R→0; I-ALU/LOAD/JALR→1; STORE→2; BRANCH→3; JAL→4.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. Hold until mem_ready. In the mem_ready cycle, assert ir_we=1 and go to DECODE.
- DECODE: no enables asserted. A legal opcode goes to EXEC. For an illegal opcode, see Configuration.
- EXEC:
  - R/I-ALU → WB.
  - LOAD/STORE → MEM.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0 → FETCH.
  - JAL: rf_we=1, wb_sel=2, pc_we=1, pc_sel=1 → FETCH.
  - JALR: rf_we=1, wb_sel=2, pc_we=1, pc_sel=2 → FETCH.
- alu_src_b=1 for all classes except R and BRANCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we = (STORE). Hold until mem_ready.
  - STORE: pc_we=1, pc_sel=0 → FETCH.
  - LOAD → WB.
- WB: rf_we=1, wb_sel = LOAD ? 1 : 0, pc_we=1, pc_sel=0 → FETCH.
- mem_ready is ignored outside FETCH and MEM.
- Enable outputs are decoded combinationally from the state and the latched class.

## Timing
- Reset: state=FETCH; latched class cleared; illegal=0. During the rst cycle every output is 0.
- mem_req rises in the first cycle after rst deasserts.
- Handshake: once mem_req is asserted, mem_req, mem_we and mem_addr_sel stay stable until mem_ready. A request never drops without mem_ready.
- Latency with zero-wait memory (mem_ready high on the first request cycle), in cycles:
  - BRANCH/JAL/JALR: 3
  - R/I-ALU: 4
  - STORE: 4
  - LOAD: 5
- Each memory wait cycle adds 1.
- At most one pc_we pulse and one rf_we pulse per instruction, each exactly one cycle wide.
- Reset mid-operation: rst takes priority in any state, including mid-handshake. No pc_we, rf_we, ir_we or mem_req is asserted in the rst cycle. The in-flight instruction is abandoned.
- br_taken is sampled only in the EXEC cycle of a BRANCH.

## Configuration
- MC_CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP asserts illegal=1 and holds every enable at 0.
  - TRAP is left only by rst.
- MC_CTRL_TRAP_EN undefined:
  - An illegal opcode in DECODE is treated as a NOP: pc_we=1, pc_sel=0 → FETCH (2 cycles).
  - The TRAP state does not exist and illegal is tied to 0.

## Structure
- Shared package mc_pkg holds:
  - opcode constants
  - immsel encodings (R..J, shared with the immediate generator)
  - pc_sel and wb_sel encodings
  - the state enum
  - the class enum
- One sub-module, mc_decode: combinational mapping opcode → {class, immsel, legal}. The FSM stays in mc_control.

## Test plan
- ADD 0x00B50533, zero-wait memory → ir_we at cycle 1; rf_we=1, wb_sel=0, pc_we=1, pc_sel=0 at cycle 4; immsel=0.
- LW 0x0005A503, mem_ready delayed 2 cycles in MEM → mem_req/mem_addr_sel=1 stable for 3 cycles; then WB with wb_sel=1, rf_we=1; immsel=1 throughout.
- BEQ 0x00B50463 run twice, br_taken=1 then 0 → pc_sel=1, then pc_sel=0, in the EXEC cycle; immsel=3; rf_we never asserted.
- JAL 0x008000EF → immsel=4, rf_we=1, wb_sel=2, pc_sel=1, all in cycle 3.
- rst asserted in MEM of SW 0x00B52023 during a wait → next cycle state=FETCH and mem_we=0; no pc_we seen.
- Opcode 0x00000037 (LUI):
  - With MC_CTRL_TRAP_EN: illegal=1 and no enables until rst.
  - Without it: pc_we=1, pc_sel=0 at cycle 2, then a new FETCH.
